// File: rtl/misr_compactor_if.sv
// Bus bundle for misr_compactor: session control, response words and
// signature/status readback. The optional data_mask member exists only when
// MISR_X_MASK_EN is defined.
interface misr_compactor_if #(
  parameter int N     = 16,
  parameter int CNT_W = 11
);
  logic             start;
  logic             data_valid;
  logic [N:0]       data_in;
`ifdef MISR_X_MASK_EN
  logic [N:0]       data_mask;
`endif
  logic             busy;
  logic             done;
  logic             pass;
  logic [N:0]       signature;
  logic [CNT_W-1:0] pattern_count;

  // Side that drives the session (BIST controller / CUT response path)
  modport master (
    output start, data_valid, data_in,
`ifdef MISR_X_MASK_EN
    output data_mask,
`endif
    input  busy, done, pass, signature, pattern_count
  );

  // Side implemented by the compactor
  modport slave (
    input  start, data_valid, data_in,
`ifdef MISR_X_MASK_EN
    input  data_mask,
`endif
    output busy, done, pass, signature, pattern_count
  );
endinterface

// File: rtl/misr_compactor.sv
// Multiple-input signature register compacting CUT response words into an
// (N+1)-bit signature over NUM_PATTERNS valid words, then flagging pass when
// the final signature equals GOLDEN.
// Optional feature macro: MISR_X_MASK_EN adds bus.data_mask, whose set bits
// force the matching data_in bits to 0 before compaction.
module misr_compactor #(
  parameter int         N            = 16,
  parameter logic [N:0] SEED         = {{N{1'b0}}, 1'b1},
  parameter int         NUM_PATTERNS = 1024,
  parameter logic [N:0] GOLDEN       = '0,
  parameter int         CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
  input  logic           clk,
  input  logic           reset,
  misr_compactor_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [N:0]       signature_q, signature_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [N:0] word;       // response word after optional X masking
  logic [N:0] shifted;    // signature shifted toward bit 0 with feedback on top
  logic [N:0] compacted;  // candidate next signature
  logic       fb;
  logic       last_word;
  logic       accept;
  logic       start_ok;

  genvar gi;

`ifdef MISR_X_MASK_EN
  for (gi = 0; gi <= N; gi++) begin : g_mask
    assign word[gi] = bus.data_in[gi] & ~bus.data_mask[gi];
  end
`else
  assign word = bus.data_in;
`endif

  // Feedback polynomial taps depend on the signature width
  if (N == 16) begin : g_taps_16
    assign fb = signature_q[16] ^ signature_q[15] ^ signature_q[13] ^
                signature_q[4]  ^ signature_q[0];
  end else if (N == 130) begin : g_taps_130
    assign fb = signature_q[130] ^ signature_q[129] ^ signature_q[128] ^
                signature_q[125] ^ signature_q[0];
  end else if (N == 131) begin : g_taps_131
    assign fb = signature_q[131] ^ signature_q[129] ^ signature_q[128] ^
                signature_q[123] ^ signature_q[0];
  end else begin : g_taps_unsupported
    $error("misr_compactor: unsupported N=%0d (use 16, 130 or 131)", N);
    assign fb = 1'b0;
  end

  for (gi = 0; gi < N; gi++) begin : g_shift
    assign shifted[gi] = signature_q[gi+1];
  end
  assign shifted[N] = fb;
  assign compacted  = shifted ^ word;

  assign start_ok  = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept    = (state_q == S_RUN) && bus.data_valid;
  assign last_word = (count_q == CNT_W'(NUM_PATTERNS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (bus.data_valid && last_word) state_d = S_DONE;
      S_DONE:  if (bus.start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: seed on start, compact on accepted words, else hold
  always_comb begin
    signature_d = signature_q;
    count_d     = count_q;
    if (start_ok) begin
      signature_d = SEED;
      count_d     = '0;
    end else if (accept) begin
      signature_d = compacted;
      count_d     = count_q + CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      signature_q <= '0;
      count_q     <= '0;
    end else begin
      signature_q <= signature_d;
      count_q     <= count_d;
    end
  end

  // Status outputs decoded from registered state
  always_comb begin
    bus.busy          = (state_q == S_RUN);
    bus.done          = (state_q == S_DONE);
    bus.pass          = (state_q == S_DONE) && (signature_q == GOLDEN);
    bus.signature     = signature_q;
    bus.pattern_count = count_q;
  end

endmodule

// File: tb/tb_misr_compactor.sv
// Self-checking bench for misr_compactor: four instances (N=16 single-word,
// N=16 four-word, N=130, N=131) driven from one directed sequence with random
// response words, checked against a shift/parity reference model.
module tb_misr_compactor;

  localparam logic [16:0]  SEED_B = 17'h0ACE1;
  localparam logic [16:0]  GOLD_B = 17'h00000;
  localparam logic [130:0] SEED_C = {3'h5, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};
  localparam logic [131:0] SEED_D = {4'h9, 128'hdead_beef_0bad_f00d_1357_9bdf_2468_ace0};

  bit   clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  misr_compactor_if #(.N(16),  .CNT_W(1)) bus_a ();
  misr_compactor_if #(.N(16),  .CNT_W(3)) bus_b ();
  misr_compactor_if #(.N(130), .CNT_W(2)) bus_c ();
  misr_compactor_if #(.N(131), .CNT_W(2)) bus_d ();

  misr_compactor #(.N(16), .SEED(17'h00001), .NUM_PATTERNS(1), .GOLDEN(17'h10000), .CNT_W(1))
    u_a (.clk(clk), .reset(reset), .bus(bus_a));
  misr_compactor #(.N(16), .SEED(SEED_B), .NUM_PATTERNS(4), .GOLDEN(GOLD_B), .CNT_W(3))
    u_b (.clk(clk), .reset(reset), .bus(bus_b));
  misr_compactor #(.N(130), .SEED(SEED_C), .NUM_PATTERNS(3), .GOLDEN('0), .CNT_W(2))
    u_c (.clk(clk), .reset(reset), .bus(bus_c));
  misr_compactor #(.N(131), .SEED(SEED_D), .NUM_PATTERNS(3), .GOLDEN('0), .CNT_W(2))
    u_d (.clk(clk), .reset(reset), .bus(bus_d));

  int n_pass  = 0;
  int n_total = 0;

  logic [131:0] taps16, taps130, taps131;
  logic [131:0] mb, mc, md, d, d2;

  // Reference step: shift toward bit 0, parity of tapped bits enters at bit n,
  // then XOR the response word in.
  function automatic logic [131:0] mstep(input logic [131:0] sig, input logic [131:0] dat,
                                         input logic [131:0] taps, input int n);
    logic [131:0] r;
    r    = sig >> 1;
    r[n] = ^(sig & taps);
    return r ^ dat;
  endfunction

  function automatic logic [131:0] rnd(input int n);
    logic [159:0] w;
    logic [131:0] one;
    w   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    one = 132'd1;
    return w[131:0] & ((one << (n + 1)) - one);
  endfunction

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    taps16  = '0; taps16[16] = 1'b1; taps16[15] = 1'b1; taps16[13] = 1'b1; taps16[4] = 1'b1; taps16[0] = 1'b1;
    taps130 = '0; taps130[130] = 1'b1; taps130[129] = 1'b1; taps130[128] = 1'b1; taps130[125] = 1'b1; taps130[0] = 1'b1;
    taps131 = '0; taps131[131] = 1'b1; taps131[129] = 1'b1; taps131[128] = 1'b1; taps131[123] = 1'b1; taps131[0] = 1'b1;

    bus_a.start = 1'b0; bus_a.data_valid = 1'b0; bus_a.data_in = '0;
    bus_b.start = 1'b0; bus_b.data_valid = 1'b0; bus_b.data_in = '0;
    bus_c.start = 1'b0; bus_c.data_valid = 1'b0; bus_c.data_in = '0;
    bus_d.start = 1'b0; bus_d.data_valid = 1'b0; bus_d.data_in = '0;
`ifdef MISR_X_MASK_EN
    bus_a.data_mask = '0; bus_b.data_mask = '0; bus_c.data_mask = '0; bus_d.data_mask = '0;
`endif

    // Reset for two cycles with random inputs (start during reset is lost)
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus_a.start = 1'($urandom()); bus_a.data_valid = 1'($urandom()); bus_a.data_in = 17'(rnd(16));
      bus_b.start = 1'($urandom()); bus_b.data_valid = 1'($urandom()); bus_b.data_in = 17'(rnd(16));
      bus_c.start = 1'($urandom()); bus_c.data_valid = 1'($urandom()); bus_c.data_in = 131'(rnd(130));
      bus_d.start = 1'($urandom()); bus_d.data_valid = 1'($urandom()); bus_d.data_in = 132'(rnd(131));
      tick();
    end
    chk("rst_sig_a",  132'(bus_a.signature), 132'd0);
    chk("rst_cnt_a",  132'(bus_a.pattern_count), 132'd0);
    chk("rst_busy_a", 132'(bus_a.busy), 132'd0);
    chk("rst_done_a", 132'(bus_a.done), 132'd0);
    chk("rst_pass_a", 132'(bus_a.pass), 132'd0);
    chk("rst_sig_b",  132'(bus_b.signature), 132'd0);
    chk("rst_busy_b", 132'(bus_b.busy), 132'd0);
    chk("rst_sig_c",  132'(bus_c.signature), 132'd0);
    chk("rst_sig_d",  132'(bus_d.signature), 132'd0);

    reset = 1'b0;
    bus_a.start = 1'b0; bus_a.data_valid = 1'b1;
    bus_b.start = 1'b0; bus_b.data_valid = 1'b0;
    bus_c.start = 1'b0; bus_c.data_valid = 1'b0;
    bus_d.start = 1'b0; bus_d.data_valid = 1'b0;
    tick();
    chk("idle_valid_ignored_sig_a", 132'(bus_a.signature), 132'd0);
    chk("idle_busy_a", 132'(bus_a.busy), 132'd0);

    // Single word, zero data
    bus_a.data_valid = 1'b0; bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    chk("start_busy_a", 132'(bus_a.busy), 132'd1);
    chk("start_seed_a", 132'(bus_a.signature), 132'h00001);
    chk("start_cnt_a",  132'(bus_a.pattern_count), 132'd0);
    bus_a.data_valid = 1'b1; bus_a.data_in = 17'h00000;
    tick();
    bus_a.data_valid = 1'b0;
    chk("zero_sig_a",  132'(bus_a.signature), 132'h10000);
    chk("zero_done_a", 132'(bus_a.done), 132'd1);
    chk("zero_pass_a", 132'(bus_a.pass), 132'd1);
    chk("zero_busy_a", 132'(bus_a.busy), 132'd0);
    chk("zero_cnt_a",  132'(bus_a.pattern_count), 132'd1);

    // Restart from DONE, single word nonzero data
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    chk("restart_done_a", 132'(bus_a.done), 132'd0);
    chk("restart_pass_a", 132'(bus_a.pass), 132'd0);
    chk("restart_seed_a", 132'(bus_a.signature), 132'h00001);
    bus_a.data_valid = 1'b1; bus_a.data_in = 17'h00001;
    tick();
    chk("nz_sig_a",  132'(bus_a.signature), 132'h10001);
    chk("nz_done_a", 132'(bus_a.done), 132'd1);
    chk("nz_pass_a", 132'(bus_a.pass), 132'd0);
    bus_a.data_in = 17'(rnd(16));
    tick();
    bus_a.data_valid = 1'b0;
    chk("done_hold_sig_a", 132'(bus_a.signature), 132'h10001);
    chk("done_hold_cnt_a", 132'(bus_a.pattern_count), 132'd1);

    // Gapped valid, four words with three idle cycles between them
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    mb = 132'(SEED_B);
    chk("gap_seed_b", 132'(bus_b.signature), mb);
    for (int w = 0; w < 4; w++) begin
      d = rnd(16);
      bus_b.data_valid = 1'b1; bus_b.data_in = 17'(d);
      tick();
      mb = mstep(mb, d, taps16, 16);
      chk($sformatf("gap_sig_b_w%0d", w),  132'(bus_b.signature), mb);
      chk($sformatf("gap_cnt_b_w%0d", w),  132'(bus_b.pattern_count), 132'(w + 1));
      chk($sformatf("gap_done_b_w%0d", w), 132'(bus_b.done), 132'(w == 3));
      if (w < 3) begin
        for (int g = 0; g < 3; g++) begin
          bus_b.data_valid = 1'b0; bus_b.data_in = 17'(rnd(16));
          tick();
          chk($sformatf("gap_hold_cnt_b_w%0d_g%0d", w, g), 132'(bus_b.pattern_count), 132'(w + 1));
          chk($sformatf("gap_hold_sig_b_w%0d_g%0d", w, g), 132'(bus_b.signature), mb);
        end
      end
    end
    bus_b.data_valid = 1'b0;
    chk("gap_pass_b", 132'(bus_b.pass), 132'(mb[16:0] == GOLD_B));
    tick();
    chk("gap_done_hold_b", 132'(bus_b.done), 132'd1);
    chk("gap_sig_hold_b",  132'(bus_b.signature), mb);

    // Ignored start mid-RUN, then reset mid-RUN, then a clean session
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    mb = 132'(SEED_B);
    for (int w = 0; w < 2; w++) begin
      d = rnd(16);
      bus_b.data_valid = 1'b1; bus_b.data_in = 17'(d);
      tick();
      mb = mstep(mb, d, taps16, 16);
    end
    bus_b.data_valid = 1'b0; bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    chk("run_start_busy_b", 132'(bus_b.busy), 132'd1);
    chk("run_start_cnt_b",  132'(bus_b.pattern_count), 132'd2);
    chk("run_start_sig_b",  132'(bus_b.signature), mb);
    reset = 1'b1; bus_b.data_valid = 1'b1; bus_b.data_in = 17'(rnd(16));
    tick();
    reset = 1'b0; bus_b.data_valid = 1'b0;
    chk("midrst_sig_b",  132'(bus_b.signature), 132'd0);
    chk("midrst_cnt_b",  132'(bus_b.pattern_count), 132'd0);
    chk("midrst_busy_b", 132'(bus_b.busy), 132'd0);
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    mb = 132'(SEED_B);
    for (int w = 0; w < 4; w++) begin
      d = rnd(16);
      bus_b.data_valid = 1'b1; bus_b.data_in = 17'(d);
      tick();
      mb = mstep(mb, d, taps16, 16);
      chk($sformatf("post_sig_b_w%0d", w), 132'(bus_b.signature), mb);
    end
    bus_b.data_valid = 1'b0;
    chk("post_done_b", 132'(bus_b.done), 132'd1);
    chk("post_cnt_b",  132'(bus_b.pattern_count), 132'd4);

    // Wide signatures: N=130 and N=131 sessions side by side
    bus_c.start = 1'b1; bus_d.start = 1'b1;
    tick();
    bus_c.start = 1'b0; bus_d.start = 1'b0;
    mc = 132'(SEED_C); md = SEED_D;
    for (int w = 0; w < 3; w++) begin
      d  = rnd(130);
      d2 = rnd(131);
      bus_c.data_valid = 1'b1; bus_c.data_in = 131'(d);
      bus_d.data_valid = 1'b1; bus_d.data_in = d2;
      tick();
      mc = mstep(mc, d, taps130, 130);
      md = mstep(md, d2, taps131, 131);
      chk($sformatf("wide_sig_c_w%0d", w), 132'(bus_c.signature), mc);
      chk($sformatf("wide_sig_d_w%0d", w), bus_d.signature, md);
    end
    bus_c.data_valid = 1'b0; bus_d.data_valid = 1'b0;
    chk("wide_done_c", 132'(bus_c.done), 132'd1);
    chk("wide_done_d", 132'(bus_d.done), 132'd1);
    chk("wide_cnt_d",  132'(bus_d.pattern_count), 132'd3);

`ifdef MISR_X_MASK_EN
    // Fully masked words must behave exactly like all-zero data
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    mb = 132'(SEED_B);
    bus_b.data_mask = '1;
    for (int w = 0; w < 4; w++) begin
      bus_b.data_valid = 1'b1; bus_b.data_in = 17'(rnd(16));
      tick();
      mb = mstep(mb, 132'd0, taps16, 16);
      chk($sformatf("mask_sig_b_w%0d", w), 132'(bus_b.signature), mb);
    end
    bus_b.data_valid = 1'b0; bus_b.data_mask = '0;
    chk("mask_done_b", 132'(bus_b.done), 132'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
